// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Shares the register-file write port between the in-order
//               pipeline writeback stage and a multi-cycle mul/div unit.
//               A mul/div result is captured in a one-entry buffer and is
//               written on the first cycle the pipeline leaves the port free.
//               If the pipeline keeps the port busy for MAXWAIT consecutive
//               cycles, the buffered result is forced out and the writeback
//               stage is stalled for one cycle.
//
// Parameters  : WIDTH    register data width
//               MAXWAIT  pipeline wins tolerated before a forced write (1..7)
//
// Ports       : clk                      clock, rising-edge active
//               rst                      asynchronous reset, active low
//               RegWriteW / RdW /        pipeline writeback request
//               ResultW
//               md_valid / md_rd /       mul/div result offer
//               md_result
//               md_ready                 mul/div result accepted this cycle
//               rf_we / rf_addr /        register-file write port
//               rf_wdata
//               StallW                   writeback stage must hold
//               pend_valid / pend_rd     outstanding buffered write, for the
//                                        hazard unit
//
// Revision    : 1.0  initial release
// ============================================================================
module writeback_arbiter #(
  parameter int WIDTH   = 32,
  parameter int MAXWAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteW,
  input  logic [4:0]       RdW,
  input  logic [WIDTH-1:0] ResultW,
  input  logic             md_valid,
  input  logic [4:0]       md_rd,
  input  logic [WIDTH-1:0] md_result,
  output logic             md_ready,
  output logic             rf_we,
  output logic [4:0]       rf_addr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic             StallW,
  output logic             pend_valid,
  output logic [4:0]       pend_rd
);

  // --------------------------------------------------------------------------
  // State encoding
  //   IDLE  : buffer empty, pipeline owns the write port
  //   HELD  : buffer full, still waiting for a free port
  //   FORCE : buffer full and it has waited long enough; it takes the port
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_held  = 2'd1;
  localparam logic [1:0] c_st_force = 2'd2;

  localparam logic [2:0] c_maxwait  = 3'(MAXWAIT);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic             r_buf_valid;
  logic [4:0]       r_buf_rd;
  logic [WIDTH-1:0] r_buf_data;
  logic [2:0]       r_age;

  // --------------------------------------------------------------------------
  // Combinational next-state and write-port decode
  // --------------------------------------------------------------------------
  logic             w_pipe_req;
  logic             w_md_ready;
  logic             w_md_load;

  logic [1:0]       w_state_nxt;
  logic             w_buf_valid_nxt;
  logic [4:0]       w_buf_rd_nxt;
  logic [WIDTH-1:0] w_buf_data_nxt;
  logic [2:0]       w_age_nxt;
  logic [2:0]       w_age_inc;

  logic             w_we;
  logic [4:0]       w_addr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_stall;

  // A write to x0 is architecturally a no-op, so it never claims the port.
  assign w_pipe_req = RegWriteW && (RdW != 5'd0);

  // Ready depends only on registered state, so there is no combinational
  // path from md_valid back to md_ready.
  assign w_md_ready = !r_buf_valid;

  // A transfer to x0 still completes (handshake) but is not buffered.
  assign w_md_load  = md_valid && w_md_ready && (md_rd != 5'd0);

  assign w_age_inc  = r_age + 3'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_buf_valid_nxt = r_buf_valid;
    w_buf_rd_nxt    = r_buf_rd;
    w_buf_data_nxt  = r_buf_data;
    w_age_nxt       = r_age;

    w_we            = 1'b0;
    w_addr          = 5'd0;
    w_wdata         = '0;
    w_stall         = 1'b0;

    case (r_state)
      c_st_idle: begin
        // Pipeline passes straight through; a newly accepted mul/div
        // result is only written from the following cycle onwards.
        if (w_pipe_req) begin
          w_we    = 1'b1;
          w_addr  = RdW;
          w_wdata = ResultW;
        end
        if (w_md_load) begin
          w_buf_valid_nxt = 1'b1;
          w_buf_rd_nxt    = md_rd;
          w_buf_data_nxt  = md_result;
          w_age_nxt       = 3'd0;
          w_state_nxt     = c_st_held;
        end
      end

      c_st_held: begin
        if (!w_pipe_req) begin
          // Port is free: drain the buffer.
          w_we            = 1'b1;
          w_addr          = r_buf_rd;
          w_wdata         = r_buf_data;
          w_buf_valid_nxt = 1'b0;
          w_buf_rd_nxt    = 5'd0;
          w_age_nxt       = 3'd0;
          w_state_nxt     = c_st_idle;
        end else if (RdW == r_buf_rd) begin
          // The younger pipeline write to the same register supersedes the
          // buffered value, which would otherwise overwrite it later.
          w_we            = 1'b1;
          w_addr          = RdW;
          w_wdata         = ResultW;
          w_buf_valid_nxt = 1'b0;
          w_buf_rd_nxt    = 5'd0;
          w_age_nxt       = 3'd0;
          w_state_nxt     = c_st_idle;
        end else begin
          // Pipeline wins this cycle; the buffered result ages.
          w_we        = 1'b1;
          w_addr      = RdW;
          w_wdata     = ResultW;
          w_age_nxt   = w_age_inc;
          if (w_age_inc >= c_maxwait) begin
            w_state_nxt = c_st_force;
          end
        end
      end

      c_st_force: begin
        // Buffer takes the port; the pipeline write is held and retried
        // next cycle by the stalled writeback stage.
        w_we            = 1'b1;
        w_addr          = r_buf_rd;
        w_wdata         = r_buf_data;
        w_stall         = 1'b1;
        w_buf_valid_nxt = 1'b0;
        w_buf_rd_nxt    = 5'd0;
        w_age_nxt       = 3'd0;
        w_state_nxt     = c_st_idle;
      end

      default: begin
        w_buf_valid_nxt = 1'b0;
        w_buf_rd_nxt    = 5'd0;
        w_age_nxt       = 3'd0;
        w_state_nxt     = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_st_idle;
      r_buf_valid <= 1'b0;
      r_buf_rd    <= 5'd0;
      r_buf_data  <= '0;
      r_age       <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_rd    <= w_buf_rd_nxt;
      r_buf_data  <= w_buf_data_nxt;
      r_age       <= w_age_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // The IDLE pass-through path is purely combinational, so every output is
  // qualified by rst to guarantee silence while reset is held.
  // --------------------------------------------------------------------------
  assign md_ready   = rst && w_md_ready;
  assign rf_we      = rst && w_we;
  assign rf_addr    = rst ? w_addr  : 5'd0;
  assign rf_wdata   = rst ? w_wdata : '0;
  assign StallW     = rst && w_stall;
  assign pend_valid = rst && r_buf_valid;
  assign pend_rd    = rst ? r_buf_rd : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Self-checking bench for writeback_arbiter. A pending-write
//               model predicts the write port every cycle; directed vectors
//               add hand-computed literal expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_writeback_arbiter;

  localparam int WIDTH   = 32;
  localparam int MAXWAIT = 4;

  logic             clk;
  logic             rst;
  logic             RegWriteW;
  logic [4:0]       RdW;
  logic [WIDTH-1:0] ResultW;
  logic             md_valid;
  logic [4:0]       md_rd;
  logic [WIDTH-1:0] md_result;
  logic             md_ready;
  logic             rf_we;
  logic [4:0]       rf_addr;
  logic [WIDTH-1:0] rf_wdata;
  logic             StallW;
  logic             pend_valid;
  logic [4:0]       pend_rd;

  int n_checks = 0;
  int n_fail   = 0;

  writeback_arbiter #(.WIDTH(WIDTH), .MAXWAIT(MAXWAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteW  (RegWriteW),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .md_valid   (md_valid),
    .md_rd      (md_rd),
    .md_result  (md_result),
    .md_ready   (md_ready),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
    .StallW     (StallW),
    .pend_valid (pend_valid),
    .pend_rd    (pend_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: at most one pending mul/div write and the number of cycles the
  // pipeline has beaten it to the port.
  // --------------------------------------------------------------------------
  bit               m_pend, n_pend;
  logic [4:0]       m_rd, n_rd;
  logic [WIDTH-1:0] m_data, n_data;
  int               m_wins, n_wins;

  always @(negedge clk) begin
    logic             e_we, e_stall, e_ready, e_pv, pipe;
    logic [4:0]       e_addr, e_prd;
    logic [WIDTH-1:0] e_data;
    e_we = 0; e_addr = 0; e_data = 0; e_stall = 0; e_ready = 0; e_pv = 0; e_prd = 0;
    n_pend = m_pend; n_rd = m_rd; n_data = m_data; n_wins = m_wins;
    pipe = RegWriteW && (RdW != 5'd0);
    if (!rst) begin
      n_pend = 0; n_rd = 0; n_data = 0; n_wins = 0;
    end else begin
      e_ready = !m_pend;
      e_pv    = m_pend;
      e_prd   = m_pend ? m_rd : 5'd0;
      if (!m_pend) begin
        if (pipe) begin e_we = 1; e_addr = RdW; e_data = ResultW; end
        if (md_valid && md_rd != 5'd0) begin
          n_pend = 1; n_rd = md_rd; n_data = md_result; n_wins = 0;
        end
      end else if (m_wins >= MAXWAIT) begin
        e_we = 1; e_addr = m_rd; e_data = m_data; e_stall = 1; n_pend = 0;
      end else if (pipe) begin
        e_we = 1; e_addr = RdW; e_data = ResultW;
        if (RdW == m_rd) n_pend = 0;
        else n_wins = m_wins + 1;
      end else begin
        e_we = 1; e_addr = m_rd; e_data = m_data; n_pend = 0;
      end
      if (!n_pend) begin n_rd = 0; n_wins = 0; end
    end
    chk("model", 64'({rf_we, rf_addr, rf_wdata, StallW, md_ready, pend_valid, pend_rd}),
                 64'({e_we, e_addr, e_data, e_stall, e_ready, e_pv, e_prd}));
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend <= 0; m_rd <= 0; m_data <= 0; m_wins <= 0;
    end else begin
      m_pend <= n_pend; m_rd <= n_rd; m_data <= n_data; m_wins <= n_wins;
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RegWriteW = 0; RdW = 0; ResultW = 0;
    md_valid = 0; md_rd = 0; md_result = 0;
  endtask

  task automatic chk_port(input string nm, input logic we, input logic [4:0] a,
                          input logic [WIDTH-1:0] d, input logic st);
    chk({nm, ".we"},    64'(rf_we),    64'(we));
    chk({nm, ".addr"},  64'(rf_addr),  64'(a));
    chk({nm, ".data"},  64'(rf_wdata), 64'(d));
    chk({nm, ".stall"}, 64'(StallW),   64'(st));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    idle_inputs();
    RegWriteW = 1; RdW = 5'd6; ResultW = 32'h11;
    #2;
    // Reset holds every output low, even with a pipeline request present.
    chk_port("reset", 0, 0, 0, 0);
    chk("reset.md_ready", 64'(md_ready), 64'(0));
    chk("reset.pend_valid", 64'(pend_valid), 64'(0));
    tick(); tick();
    idle_inputs();
    rst = 1;
    #1;
    chk("release.md_ready", 64'(md_ready), 64'(1));

    // Pipeline pass-through in IDLE.
    tick();
    RegWriteW = 1; RdW = 5'd5; ResultW = 32'hAA;
    #1;
    chk_port("idle_pass", 1, 5'd5, 32'hAA, 0);
    tick();
    idle_inputs();

    // Mul/div accept with idle pipeline, written the next cycle.
    md_valid = 1; md_rd = 5'd7; md_result = 32'h1234;
    #1;
    chk("md_accept.ready", 64'(md_ready), 64'(1));
    chk("md_accept.we", 64'(rf_we), 64'(0));
    tick();
    md_valid = 0;
    #1;
    chk_port("md_write", 1, 5'd7, 32'h1234, 0);
    chk("md_write.ready", 64'(md_ready), 64'(0));
    tick();
    chk("md_after.ready", 64'(md_ready), 64'(1));
    chk("md_after.pend", 64'(pend_valid), 64'(0));

    // Pipeline hogs the port: 4 pipeline writes, then a forced write.
    md_valid = 1; md_rd = 5'd7; md_result = 32'h77;
    tick();
    md_valid = 0;
    RegWriteW = 1; RdW = 5'd3; ResultW = 32'h33;
    for (int i = 0; i < MAXWAIT; i++) begin
      #1;
      chk_port($sformatf("hog%0d", i), 1, 5'd3, 32'h33, 0);
      tick();
    end
    #1;
    chk_port("force", 1, 5'd7, 32'h77, 1);
    tick();
    #1;
    chk_port("retry", 1, 5'd3, 32'h33, 0);
    chk("retry.pend", 64'(pend_valid), 64'(0));
    tick();
    idle_inputs();

    // Supersede: pipeline writes the buffered register.
    md_valid = 1; md_rd = 5'd9; md_result = 32'h99;
    tick();
    md_valid = 0;
    RegWriteW = 1; RdW = 5'd9; ResultW = 32'h55;
    #1;
    chk("super.pend_rd", 64'(pend_rd), 64'(9));
    chk_port("super", 1, 5'd9, 32'h55, 0);
    tick();
    idle_inputs();
    #1;
    chk("super.pend_after", 64'(pend_valid), 64'(0));
    chk("super.no_late_we", 64'(rf_we), 64'(0));
    tick();
    chk("super.no_late_we2", 64'(rf_we), 64'(0));

    // Transfer to x0 is swallowed.
    md_valid = 1; md_rd = 5'd0; md_result = 32'hDEAD;
    #1;
    chk("x0.ready", 64'(md_ready), 64'(1));
    tick();
    md_valid = 0;
    #1;
    chk("x0.we", 64'(rf_we), 64'(0));
    chk("x0.pend", 64'(pend_valid), 64'(0));
    chk("x0.ready_after", 64'(md_ready), 64'(1));
    tick();

    // Asynchronous reset while HELD: buffered result is lost.
    md_valid = 1; md_rd = 5'd12; md_result = 32'hC0;
    tick();
    md_valid = 0;
    RegWriteW = 1; RdW = 5'd4; ResultW = 32'h44;
    #1;
    chk("held.pend", 64'(pend_valid), 64'(1));
    #1;
    rst = 0;
    #1;
    chk_port("async_rst", 0, 0, 0, 0);
    chk("async_rst.ready", 64'(md_ready), 64'(0));
    chk("async_rst.pend", 64'({pend_valid, pend_rd}), 64'(0));
    tick();
    rst = 1;
    #1;
    chk("rst_release.ready", 64'(md_ready), 64'(1));
    chk("rst_release.pend", 64'(pend_valid), 64'(0));
    chk_port("rst_release", 1, 5'd4, 32'h44, 0);
    tick();
    idle_inputs();

    // Mixed traffic, checked every cycle by the model.
    for (int i = 0; i < 60; i++) begin
      RegWriteW = 1'($urandom_range(0, 1));
      RdW       = 5'($urandom_range(0, 4));
      ResultW   = $urandom;
      md_valid  = 1'($urandom_range(0, 1));
      md_rd     = 5'($urandom_range(0, 4));
      md_result = $urandom;
      tick();
    end
    idle_inputs();
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
